// File: rtl/nes_video_pkg.sv
// Shared definitions for the NES video capture path: default raster geometry,
// palette width, capture FSM encoding and a saturating counter helper.
package nes_video_pkg;

  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_COLOR_W  = 6;
  localparam int DEF_CNT_W    = 16;
  localparam int DROP_W       = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } cap_state_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: one write port, one registered read port, bank
// chosen by the address MSB so the capture side and reader never collide.
module frame_bank_ram #(
  parameter int AW = 17,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Each bank is padded up to a power of two so the bank bit is a plain MSB.
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ppu_frame_capture.sv
// Double-buffered PPU frame grabber: captures one active frame into the write
// bank and publishes it atomically at the last active pixel unless the reader holds a lock.
module ppu_frame_capture
  import nes_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int CNT_W    = DEF_CNT_W,
  localparam int ADDR_W  = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic [8:0]         cycle,
  input  logic [8:0]         scanline,
  input  logic [COLOR_W-1:0] color,
  input  logic               arm,
  input  logic               single_shot,
  input  logic               rd_lock,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COLOR_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               pub_valid,
  output logic               frame_done,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_count,
  output logic [DROP_W-1:0]  drop_count
);

  cap_state_e          state_q, state_d;
  logic                wbank_q, wbank_d;
  logic                pub_valid_q, pub_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]    frame_count_q, frame_count_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;

  logic                sof;
  logic                last;
  logic                in_win;
  logic                ram_we;
  logic [ADDR_W-1:0]   pix_addr;

  assign sof    = ce && (scanline == 9'd0) && (cycle == 9'd0);
  assign last   = ce && (scanline == 9'(V_ACTIVE - 1)) && (cycle == 9'(H_ACTIVE - 1));
  assign in_win = (cycle < 9'(H_ACTIVE)) && (scanline < 9'(V_ACTIVE));

  assign pix_addr = ADDR_W'(32'(scanline) * 32'(H_ACTIVE) + 32'(cycle));

  // A glitch SOF while in CAPTURE simply rewrites from (0,0) in the same bank;
  // only LAST can publish, so a torn frame never becomes visible.
  always_comb begin
    state_d       = state_q;
    wbank_d       = wbank_q;
    pub_valid_d   = pub_valid_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    ram_we        = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        if (sof) begin
          state_d = CAPTURE;
          ram_we  = 1'b1;
        end
      end
      CAPTURE: begin
        ram_we = ce && in_win;
        if (last) begin
          if (!rd_lock) begin
            wbank_d       = ~wbank_q;
            pub_valid_d   = 1'b1;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + CNT_W'(1);
          end else begin
            drop_count_d  = sat_inc(drop_count_q);
          end
          state_d = (single_shot && !rd_lock) ? DONE : WAIT_SOF;
        end
      end
      DONE: begin
        if (arm) begin
          state_d = WAIT_SOF;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_valid_d = rd_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wbank_q       <= 1'b0;
      pub_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      rd_valid_q    <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      wbank_q       <= wbank_d;
      pub_valid_q   <= pub_valid_d;
      frame_done_q  <= frame_done_d;
      rd_valid_q    <= rd_valid_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // Reader bank is taken from the current pointer, so a read in the swap cycle sees pre-swap data.
  frame_bank_ram #(
    .AW (ADDR_W + 1),
    .DW (COLOR_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   ({wbank_q, pix_addr}),
    .wdata   (color),
    .re      (rd_en),
    .raddr   ({~wbank_q, rd_addr}),
    .rdata   (rd_data)
  );

  assign rd_valid    = rd_valid_q;
  assign pub_valid   = pub_valid_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q == WAIT_SOF) || (state_q == CAPTURE);
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_ppu_frame_capture.sv
// Self-checking bench for ppu_frame_capture on a small 8x4 window inside a
// 12-dot x 6-line model PPU raster with ce asserted on every dot.
module tb_ppu_frame_capture;
  import nes_video_pkg::*;

  localparam int H          = 8;
  localparam int V          = 4;
  localparam int DOTS       = 12;
  localparam int LINES      = 6;
  localparam int FRAME_DOTS = DOTS * LINES;
  localparam int LAST_IDX   = (V - 1) * DOTS + (H - 1);
  localparam int AW         = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic [8:0]  cycle;
  logic [8:0]  scanline;
  logic [5:0]  color;
  logic        arm;
  logic        single_shot;
  logic        rd_lock;
  logic        rd_en;
  logic [AW-1:0] rd_addr;
  logic [5:0]  rd_data;
  logic        rd_valid;
  logic        pub_valid;
  logic        frame_done;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int color_mode;
  int done_pulses;
  int ram_writes;
  logic [5:0] exp_q[$];
  logic [5:0] got_exp;

  always #5 clk = ~clk;

  ppu_frame_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .COLOR_W  (6),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .cycle       (cycle),
    .scanline    (scanline),
    .color       (color),
    .arm         (arm),
    .single_shot (single_shot),
    .rd_lock     (rd_lock),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .pub_valid   (pub_valid),
    .frame_done  (frame_done),
    .busy        (busy),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_dots(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      scanline = 9'(i / DOTS);
      cycle    = 9'(i % DOTS);
      ce       = 1'b1;
      color    = (color_mode < 0) ? 6'(((i / DOTS) * 8 + (i % DOTS)) & 63) : 6'(color_mode);
      #1;
      if (dut.ram_we) ram_writes++;
      tick();
      if (frame_done) done_pulses++;
    end
    ce = 1'b0;
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) run_dots(0, FRAME_DOTS - 1);
  endtask

  task automatic do_reset;
    reset_n = 1'b0; ce = 1'b0; cycle = '0; scanline = '0; color = '0;
    arm = 1'b0; single_shot = 1'b0; rd_lock = 1'b0; rd_en = 1'b0; rd_addr = '0;
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic pulse_arm;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic read_all(input string name, input int mode);
    for (int a = 0; a < H * V; a++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      exp_q.push_back((mode < 0) ? 6'(a & 63) : 6'(mode));
      tick();
      checks++;
      if (rd_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s rd_valid addr %0d got %b expected 1", name, a, rd_valid);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s scoreboard empty got %0d expected entry", name, rd_data);
      end else begin
        got_exp = exp_q.pop_front();
        if (rd_data !== got_exp) begin
          errors++;
          $display("[TB] FAIL %s addr %0d got %0d expected %0d", name, a, rd_data, got_exp);
        end
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s rd_valid idle got %b expected 0", name, rd_valid);
    end
  endtask

  task automatic test_reset;
    do_reset();
    check_val("reset_pub_valid", int'(pub_valid), 0);
    check_val("reset_frame_done", int'(frame_done), 0);
    check_val("reset_rd_valid", int'(rd_valid), 0);
    check_val("reset_rd_data", int'(rd_data), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_frame_count", int'(frame_count), 0);
    check_val("reset_drop_count", int'(drop_count), 0);
    check_val("reset_state", int'(dut.state_q), int'(IDLE));
  endtask

  task automatic test_basic_capture;
    do_reset();
    color_mode = -1;
    pulse_arm();
    check_val("basic_busy_armed", int'(busy), 1);
    done_pulses = 0;
    run_dots(0, LAST_IDX - 1);
    check_val("basic_done_before_last", done_pulses, 0);
    check_val("basic_count_before_last", int'(frame_count), 0);
    run_dots(LAST_IDX, LAST_IDX);
    check_val("basic_frame_done", int'(frame_done), 1);
    check_val("basic_frame_count", int'(frame_count), 1);
    check_val("basic_pub_valid", int'(pub_valid), 1);
    done_pulses = 0;
    run_dots(LAST_IDX + 1, FRAME_DOTS - 1);
    check_val("basic_done_width", done_pulses, 0);
    read_all("basic_read", -1);
  endtask

  task automatic test_no_arm;
    do_reset();
    color_mode = -1;
    done_pulses = 0;
    ram_writes = 0;
    run_frames(3);
    check_val("noarm_state", int'(dut.state_q), int'(IDLE));
    check_val("noarm_busy", int'(busy), 0);
    check_val("noarm_frame_count", int'(frame_count), 0);
    check_val("noarm_pub_valid", int'(pub_valid), 0);
    check_val("noarm_done_pulses", done_pulses, 0);
    check_val("noarm_ram_writes", ram_writes, 0);
  endtask

  task automatic test_lock;
    do_reset();
    pulse_arm();
    color_mode = 5;
    run_frames(1);
    check_val("lock_a_count", int'(frame_count), 1);
    rd_lock = 1'b1;
    color_mode = 9;
    done_pulses = 0;
    run_frames(1);
    check_val("lock_b_drop", int'(drop_count), 1);
    check_val("lock_b_count", int'(frame_count), 1);
    check_val("lock_b_no_done", done_pulses, 0);
    read_all("lock_b_read", 5);
    rd_lock = 1'b0;
    color_mode = 12;
    run_frames(1);
    check_val("lock_c_count", int'(frame_count), 2);
    check_val("lock_c_drop", int'(drop_count), 1);
    read_all("lock_c_read", 12);
  endtask

  task automatic test_single_shot;
    do_reset();
    single_shot = 1'b1;
    color_mode = -1;
    pulse_arm();
    done_pulses = 0;
    run_frames(3);
    check_val("ss_count", int'(frame_count), 1);
    check_val("ss_done_pulses", done_pulses, 1);
    check_val("ss_state", int'(dut.state_q), int'(DONE));
    check_val("ss_busy", int'(busy), 0);
    pulse_arm();
    check_val("ss_rearm_busy", int'(busy), 1);
    run_frames(1);
    check_val("ss_rearm_count", int'(frame_count), 2);
    check_val("ss_rearm_state", int'(dut.state_q), int'(DONE));
    single_shot = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    pulse_arm();
    color_mode = 5;
    run_frames(1);
    color_mode = 9;
    run_dots(0, LAST_IDX - 1);
    rd_en = 1'b1;
    rd_addr = AW'(3);
    exp_q.push_back(6'd5);
    run_dots(LAST_IDX, LAST_IDX);
    check_val("b2b_swap_done", int'(frame_done), 1);
    check_val("b2b_swap_valid", int'(rd_valid), 1);
    got_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
    check_val("b2b_swap_cycle_read", int'(rd_data), int'(got_exp));
    rd_addr = AW'(3);
    exp_q.push_back(6'd9);
    run_dots(LAST_IDX + 1, LAST_IDX + 1);
    check_val("b2b_next_valid", int'(rd_valid), 1);
    got_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
    check_val("b2b_next_read", int'(rd_data), int'(got_exp));
    rd_en = 1'b0;
    run_dots(LAST_IDX + 2, FRAME_DOTS - 1);
    check_val("b2b_count", int'(frame_count), 2);
  endtask

  task automatic test_reset_mid_capture;
    do_reset();
    pulse_arm();
    color_mode = -1;
    run_frames(1);
    rd_en = 1'b1;
    rd_addr = AW'(5);
    tick();
    rd_en = 1'b0;
    run_dots(0, 30);
    reset_n = 1'b0;
    #1;
    check_val("midrst_busy", int'(busy), 0);
    check_val("midrst_pub_valid", int'(pub_valid), 0);
    check_val("midrst_frame_count", int'(frame_count), 0);
    check_val("midrst_rd_data", int'(rd_data), 0);
    check_val("midrst_rd_valid", int'(rd_valid), 0);
    check_val("midrst_state", int'(dut.state_q), int'(IDLE));
    tick();
    reset_n = 1'b1;
    tick();
    pulse_arm();
    run_frames(1);
    check_val("midrst_recount", int'(frame_count), 1);
    read_all("midrst_read", -1);
    rd_lock = 1'b1;
    run_frames(254);
    check_val("sat_drop_254", int'(drop_count), 254);
    run_frames(46);
    check_val("sat_drop_255", int'(drop_count), 255);
    check_val("sat_frame_count", int'(frame_count), 1);
    rd_lock = 1'b0;
  endtask

  initial begin
    color_mode = -1;
    done_pulses = 0;
    ram_writes = 0;
    test_reset();
    test_basic_capture();
    test_no_arm();
    test_lock();
    test_single_shot();
    test_back_to_back();
    test_reset_mid_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
